// File: rtl/npu_axi_cfg_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_axi_cfg_slave_if : AXI4 (full) bus bundle for the NPU config slave   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface npu_axi_cfg_slave_if #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     awid;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awlock;
  logic [3:0]                  awcache;
  logic [2:0]                  awprot;
  logic [3:0]                  awqos;
  logic [3:0]                  awregion;
  logic [AXI_USER_WIDTH-1:0]   awuser;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic [AXI_USER_WIDTH-1:0]   wuser;
  logic                        wvalid;
  logic                        wready;
  logic [AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;
  logic [AXI_USER_WIDTH-1:0]   buser;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ID_WIDTH-1:0]     arid;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arlock;
  logic [3:0]                  arcache;
  logic [2:0]                  arprot;
  logic [3:0]                  arqos;
  logic [3:0]                  arregion;
  logic [AXI_USER_WIDTH-1:0]   aruser;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_ID_WIDTH-1:0]     rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic [AXI_USER_WIDTH-1:0]   ruser;
  logic                        rvalid;
  logic                        rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface
`default_nettype wire

// File: rtl/npu_axi_cfg_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | npu_axi_cfg_slave : AXI4 slave register bank (core/wrap cfg, ctrl, RO)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module npu_axi_cfg_slave #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 10,
  parameter int CORE_REGS      = 16,
  parameter int WRAP_REGS      = 32,
  parameter int STATUS_REGS    = 8,
  parameter int OUT_REGS       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  npu_axi_cfg_slave_if.slave                  axi,
  output logic [CORE_REGS*AXI_DATA_WIDTH-1:0] core_cfg_o,
  output logic [WRAP_REGS*AXI_DATA_WIDTH-1:0] wrap_cfg_o,
  output logic                                start_pulse_o,
  output logic [2:0]                          start_mode_o,
  output logic                                stop_pulse_o,
  input  logic [STATUS_REGS*AXI_DATA_WIDTH-1:0] status_in_i,
  input  logic [OUT_REGS*AXI_DATA_WIDTH-1:0]  out_data_in_i
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = AXI_ADDR_WIDTH - 2;
  typedef logic [IW-1:0] widx_t;

  // Region bases as word indices (byte address >> 2)
  localparam int C_WRAP_BASE = 'h80;
  localparam int C_START     = 'hC0;
  localparam int C_STOP      = 'hC1;
  localparam int C_STAT_BASE = 'hC8;
  localparam int C_OUT_BASE  = 'h100;
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DW-1:0] core_q [CORE_REGS];
  logic [DW-1:0] wrap_q [WRAP_REGS];
  logic          start_pulse_q, stop_pulse_q;
  logic [2:0]    start_mode_q;

  w_state_e                w_state_q;
  logic                    awready_q, wready_q, bvalid_q, werr_q;
  logic [AXI_ID_WIDTH-1:0] bid_q;
  logic [1:0]              bresp_q, wburst_q;
  logic [7:0]              wlen_q, wcnt_q;
  widx_t                   waddr_q, waddr_d;

  r_state_e                r_state_q;
  logic                    arready_q, rvalid_q, rlast_q;
  logic [AXI_ID_WIDTH-1:0] rid_q;
  logic [1:0]              rresp_q, rburst_q, rd_burst;
  logic [7:0]              rlen_q, rcnt_q;
  logic [DW-1:0]           rdata_q, rd_data;
  logic                    rd_err;
  widx_t                   raddr_q, raddr_d, rd_addr;

  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

  logic wr_beat, wr_final, wr_core, wr_wrap, wr_start, wr_stop, wr_bad;
  assign wr_beat  = (w_state_q == W_DATA) && axi.wvalid && wready_q;
  assign wr_final = (wcnt_q == wlen_q);
  assign wr_core  = waddr_q < widx_t'(CORE_REGS);
  assign wr_wrap  = (waddr_q >= widx_t'(C_WRAP_BASE)) &&
                    (waddr_q <  widx_t'(C_WRAP_BASE + WRAP_REGS));
  assign wr_start = waddr_q == widx_t'(C_START);
  assign wr_stop  = waddr_q == widx_t'(C_STOP);
  // A beat is bad if it targets a non-writable word or its wlast disagrees with the beat count
  assign wr_bad   = !(wr_core || wr_wrap || wr_start || wr_stop) || (axi.wlast != wr_final);
  assign waddr_d  = (wburst_q == C_BURST_FIXED) ? waddr_q : waddr_q + widx_t'(1);

  assign rd_addr  = (r_state_q == R_IDLE) ? axi.araddr[AXI_ADDR_WIDTH-1:2] : raddr_q;
  assign rd_burst = (r_state_q == R_IDLE) ? axi.arburst : rburst_q;
  assign raddr_d  = (rd_burst == C_BURST_FIXED) ? rd_addr : rd_addr + widx_t'(1);

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int i = 0; i < CORE_REGS; i++)
      if (rd_addr == widx_t'(i)) begin rd_data = core_q[i]; rd_err = 1'b0; end
    for (int i = 0; i < WRAP_REGS; i++)
      if (rd_addr == widx_t'(C_WRAP_BASE + i)) begin rd_data = wrap_q[i]; rd_err = 1'b0; end
    for (int i = 0; i < STATUS_REGS; i++)
      if (rd_addr == widx_t'(C_STAT_BASE + i)) begin rd_data = status_in_i[i*DW +: DW]; rd_err = 1'b0; end
    for (int i = 0; i < OUT_REGS; i++)
      if (rd_addr == widx_t'(C_OUT_BASE + i)) begin rd_data = out_data_in_i[i*DW +: DW]; rd_err = 1'b0; end
    if (rd_addr == widx_t'(C_START)) begin rd_data = DW'(start_mode_q); rd_err = 1'b0; end
    if (rd_addr == widx_t'(C_STOP)) rd_err = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_REGS; i++) core_q[i] <= '0;
      for (int i = 0; i < WRAP_REGS; i++) wrap_q[i] <= '0;
    end else if (wr_beat) begin
      for (int i = 0; i < CORE_REGS; i++)
        if (waddr_q == widx_t'(i)) core_q[i] <= f_merge(core_q[i], axi.wdata, axi.wstrb);
      for (int i = 0; i < WRAP_REGS; i++)
        if (waddr_q == widx_t'(C_WRAP_BASE + i)) wrap_q[i] <= f_merge(wrap_q[i], axi.wdata, axi.wstrb);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
      start_mode_q  <= 3'd0;
    end else begin
      start_pulse_q <= wr_beat && wr_start;
      stop_pulse_q  <= wr_beat && wr_stop && axi.wstrb[0] && axi.wdata[0];
      if (wr_beat && wr_start && axi.wstrb[0]) start_mode_q <= axi.wdata[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= C_RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      wburst_q  <= 2'b00;
      werr_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= axi.awid;
            waddr_q   <= axi.awaddr[AXI_ADDR_WIDTH-1:2];
            wlen_q    <= axi.awlen;
            wburst_q  <= axi.awburst;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_beat) begin
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_q + 8'd1;
            werr_q  <= werr_q || wr_bad;
            if (wr_final) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (werr_q || wr_bad) ? C_RESP_SLVERR : C_RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // The first beat loads from araddr on the ar handshake; later beats reload on each r handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= C_RESP_OKAY;
      rdata_q   <= '0;
      rburst_q  <= 2'b00;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      raddr_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi.arvalid && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= axi.arid;
            rlen_q    <= axi.arlen;
            rburst_q  <= axi.arburst;
            rcnt_q    <= 8'd0;
            rdata_q   <= rd_data;
            rresp_q   <= rd_err ? C_RESP_SLVERR : C_RESP_OKAY;
            rlast_q   <= (axi.arlen == 8'd0);
            rvalid_q  <= 1'b1;
            raddr_q   <= raddr_d;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              rdata_q <= rd_data;
              rresp_q <= rd_err ? C_RESP_SLVERR : C_RESP_OKAY;
              rcnt_q  <= rcnt_q + 8'd1;
              rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
              raddr_q <= raddr_d;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.buser   = '0;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.ruser   = '0;

  assign start_pulse_o = start_pulse_q;
  assign stop_pulse_o  = stop_pulse_q;
  assign start_mode_o  = start_mode_q;

  for (genvar gi = 0; gi < CORE_REGS; gi++) begin : g_core_out
    assign core_cfg_o[gi*DW +: DW] = core_q[gi];
  end
  for (genvar gi = 0; gi < WRAP_REGS; gi++) begin : g_wrap_out
    assign wrap_cfg_o[gi*DW +: DW] = wrap_q[gi];
  end

  logic unused_sig;
  assign unused_sig = ^{axi.awsize, axi.awlock, axi.awcache, axi.awprot, axi.awqos,
                        axi.awregion, axi.awuser, axi.wuser, axi.arsize, axi.arlock,
                        axi.arcache, axi.arprot, axi.arqos, axi.arregion, axi.aruser,
                        axi.awaddr[1:0], axi.araddr[1:0]};
endmodule
`default_nettype wire
